// File: rtl/cpu_multi_if.sv
// Unified instruction/data memory bus for cpu_multi.
// req is registered by the core; an access completes in the cycle where req && ready.
interface cpu_multi_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/cpu_multi.sv
// Multi-cycle MIPS-subset core with a shared ALU and one unified memory port.
// Optional build macro CPU_MULTI_TRACE_EN adds retire/retire_pc trace outputs.
module cpu_multi #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter bit          WORD_ADDR_ONLY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  cpu_multi_if.master mem,
  output logic        halted,
  output logic [31:0] pc_dbg,
  output logic [3:0]  state_dbg
`ifdef CPU_MULTI_TRACE_EN
  ,
  output logic        retire,
  output logic [31:0] retire_pc
`endif
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEMADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25, FN_SLT = 6'h2A;

  state_t      state, dec_next;
  logic [31:0] pc, ir, mdr, a, b, alu_out;
  logic [31:0] regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, ea, alu_r, branch_pc, jump_pc;
  logic        funct_ok, misaligned;
  logic        unused_shamt;

  assign opcode       = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign unused_shamt = ^ir[10:6];
  assign imm_sext     = {{16{ir[15]}}, ir[15:0]};
  assign ea           = a + imm_sext;
  assign misaligned   = WORD_ADDR_ONLY && (ea[1:0] != 2'b00);
  assign branch_pc    = (a == b) ? alu_out : pc;
  assign jump_pc      = {pc[31:28], ir[25:0], 2'b00};

  assign pc_dbg    = pc;
  assign state_dbg = state;

  function automatic logic [31:0] bus_addr(input logic [31:0] x);
    return WORD_ADDR_ONLY ? {x[31:2], 2'b00} : x;
  endfunction

  always_comb begin
    funct_ok = 1'b1;
    alu_r    = '0;
    case (funct)
      FN_ADD:  alu_r = a + b;
      FN_SUB:  alu_r = a - b;
      FN_AND:  alu_r = a & b;
      FN_OR:   alu_r = a | b;
      FN_SLT:  alu_r = {31'b0, $signed(a) < $signed(b)};
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_RTYPE:     dec_next = funct_ok ? S_EXEC_R : S_HALT;
      OP_LW, OP_SW: dec_next = S_MEMADDR;
      OP_BEQ:       dec_next = S_BRANCH;
      OP_J:         dec_next = S_JUMP;
      OP_ADDI:      dec_next = S_EXEC_I;
      default:      dec_next = S_HALT;
    endcase
  end

  // Every transition back to FETCH raises the next fetch request itself, so the
  // registered req is already high in FETCH and zero-wait fetches take one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      pc            <= RESET_PC;
      ir            <= '0;
      mdr           <= '0;
      a             <= '0;
      b             <= '0;
      alu_out       <= '0;
      halted        <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i[4:0]] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem.mem_req) begin
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= bus_addr(pc);
          end else if (mem.mem_ready) begin
            ir          <= mem.mem_rdata;
            pc          <= pc + 32'd4;
            mem.mem_req <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          a       <= regs[rs];
          b       <= regs[rt];
          alu_out <= pc + {imm_sext[29:0], 2'b00};
          state   <= dec_next;
          if (dec_next == S_HALT) halted <= 1'b1;
        end
        S_EXEC_R: begin
          alu_out <= alu_r;
          state   <= S_WB_R;
        end
        S_EXEC_I: begin
          alu_out <= ea;
          state   <= S_WB_I;
        end
        S_WB_R, S_WB_I, S_WB_MEM: begin
          if (state == S_WB_R && rd != 5'd0) regs[rd] <= alu_out;
          if (state == S_WB_I && rt != 5'd0) regs[rt] <= alu_out;
          if (state == S_WB_MEM && rt != 5'd0) regs[rt] <= mdr;
          mem.mem_req  <= 1'b1;
          mem.mem_we   <= 1'b0;
          mem.mem_addr <= bus_addr(pc);
          state        <= S_FETCH;
        end
        S_MEMADDR: begin
          alu_out <= ea;
          if (misaligned) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= (opcode == OP_SW);
            mem.mem_addr <= bus_addr(ea);
            if (opcode == OP_SW) mem.mem_wdata <= b;
            state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          if (mem.mem_req && mem.mem_ready) begin
            mdr         <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            state       <= S_WB_MEM;
          end
        end
        S_MEM_WR: begin
          if (mem.mem_req && mem.mem_ready) begin
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= bus_addr(pc);
            state        <= S_FETCH;
          end
        end
        S_BRANCH, S_JUMP: begin
          pc           <= (state == S_JUMP) ? jump_pc : branch_pc;
          mem.mem_req  <= 1'b1;
          mem.mem_we   <= 1'b0;
          mem.mem_addr <= bus_addr((state == S_JUMP) ? jump_pc : branch_pc);
          state        <= S_FETCH;
        end
        S_HALT: begin
          halted      <= 1'b1;
          mem.mem_req <= 1'b0;
        end
        default: begin
          halted      <= 1'b1;
          mem.mem_req <= 1'b0;
          state       <= S_HALT;
        end
      endcase
    end
  end

`ifdef CPU_MULTI_TRACE_EN
  logic [31:0] fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) fetch_pc <= '0;
    else if (state == S_FETCH && mem.mem_req && mem.mem_ready) fetch_pc <= pc;
  end

  assign retire_pc = fetch_pc;
  assign retire    = (state == S_WB_R) || (state == S_WB_I) || (state == S_WB_MEM) ||
                     (state == S_BRANCH) || (state == S_JUMP) ||
                     (state == S_MEM_WR && mem.mem_req && mem.mem_ready);
`endif
endmodule

// File: tb/tb_cpu_multi.sv
// Self-checking bench for cpu_multi: directed programs plus random programs
// compared against an instruction-level reference model.
module tb_cpu_multi;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HALT_W   = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_multi_if bus ();
  logic        halted;
  logic [31:0] pc_dbg;
  logic [3:0]  state_dbg;

  cpu_multi #(.RESET_PC(RESET_PC), .WORD_ADDR_ONLY(1'b1)) dut (
    .clk(clk), .rst(rst), .mem(bus), .halted(halted), .pc_dbg(pc_dbg), .state_dbg(state_dbg)
  );

  // Memory model: [0x40,0x200) is the data region with its own wait count.
  logic [31:0] mem [1024];
  logic [31:0] mm  [1024];
  int unsigned fetch_wait = 0, data_wait = 0, wait_cnt = 0, cyc = 0;

  function automatic bit is_data(input logic [31:0] x);
    return (x >= 32'h40) && (x < 32'h200);
  endfunction
  function automatic logic [9:0] widx(input logic [31:0] x);
    return x[11:2];
  endfunction

  assign bus.mem_rdata = mem[widx(bus.mem_addr)];
  assign bus.mem_ready = bus.mem_req &&
                         (wait_cnt >= (is_data(bus.mem_addr) ? data_wait : fetch_wait));

  typedef struct packed { logic [31:0] addr; logic [31:0] data; int unsigned cyc; } acc_t;
  acc_t writes[$];
  acc_t fetches[$];
  int unsigned data_rd_cycles = 0, data_rd_at40 = 0, req_while_halted = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || !bus.mem_req) wait_cnt <= 0;
    else if (bus.mem_ready) begin
      wait_cnt <= 0;
      if (bus.mem_we) begin
        mem[widx(bus.mem_addr)] = bus.mem_wdata;
        writes.push_back('{bus.mem_addr, bus.mem_wdata, cyc});
      end else if (!is_data(bus.mem_addr)) begin
        fetches.push_back('{bus.mem_addr, bus.mem_rdata, cyc});
      end
    end else wait_cnt <= wait_cnt + 1;
  end

  always @(negedge clk) begin
    if (bus.mem_req && !bus.mem_we && is_data(bus.mem_addr)) begin
      data_rd_cycles++;
      if (bus.mem_addr == 32'h40) data_rd_at40++;
    end
    if (halted && bus.mem_req) req_while_halted++;
  end

  int unsigned n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [31:0] prog[$];
  task automatic load_prog();
    foreach (prog[k]) mem[k] = prog[k];
  endtask

  int unsigned wbase, fbase, rdbase, rd40base, hbase;
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    wbase = writes.size(); fbase = fetches.size();
    rdbase = data_rd_cycles; rd40base = data_rd_at40; hbase = req_while_halted;
    rst = 1'b0;
  endtask

  // span = cycles from the first requesting cycle to the first cycle halted is seen.
  task automatic run_to_halt(input int unsigned budget, output int unsigned span);
    int unsigned start = 0;
    bit seen = 1'b0, done = 1'b0;
    span = 0;
    for (int unsigned k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (!seen && bus.mem_req) begin seen = 1'b1; start = cyc; end
      if (halted) begin done = 1'b1; span = cyc - start; end
    end
    check("halt_reached", {31'b0, done}, 32'd1);
  endtask

  // Instruction-level reference: ISA semantics plus per-class latency.
  task automatic model_run(output int unsigned cycles);
    logic [31:0] r [32];
    logic [31:0] w, s, x, y, res;
    for (int unsigned i = 0; i < 32; i++) r[i] = '0;
    cycles = 0;
    foreach (prog[k]) begin
      w = prog[k];
      s = {{16{w[15]}}, w[15:0]};
      x = r[w[25:21]];
      y = r[w[20:16]];
      case (w[31:26])
        6'h00: begin
          case (w[5:0])
            6'h20: res = x + y;
            6'h22: res = x - y;
            6'h24: res = x & y;
            6'h25: res = x | y;
            default: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          endcase
          if (w[15:11] != 5'd0) r[w[15:11]] = res;
          cycles += 4 + fetch_wait;
        end
        6'h08: begin
          if (w[20:16] != 5'd0) r[w[20:16]] = x + s;
          cycles += 4 + fetch_wait;
        end
        6'h23: begin
          res = x + s;
          if (w[20:16] != 5'd0) r[w[20:16]] = mm[widx(res)];
          cycles += 5 + fetch_wait + data_wait;
        end
        6'h2B: begin
          res = x + s;
          mm[widx(res)] = y;
          cycles += 4 + fetch_wait + data_wait;
        end
        default: begin
          cycles += 2 + fetch_wait;
          break;
        end
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned span, exp_span, hit;
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int unsigned i = 0; i < 1024; i++) mem[i] = '0;

    // Reset values, first fetch, then addi/addi/add/sw.
    prog = '{enc_i(6'h08, 0, 1, 16'd5), enc_i(6'h08, 0, 2, 16'd7), enc_r(1, 2, 3, 6'h20),
             enc_i(6'h2B, 0, 3, 16'h40), HALT_W};
    load_prog();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_pc", pc_dbg, RESET_PC);
    @(negedge clk);
    wbase = writes.size(); fbase = fetches.size();
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_req", {31'b0, bus.mem_req}, 32'd1);
    check("first_addr", bus.mem_addr, RESET_PC);
    @(posedge clk); #1;
    check("pc_after_fetch", pc_dbg, RESET_PC + 32'd4);
    run_to_halt(200, span);
    check("sw_count", writes.size() - wbase, 32'd1);
    if (writes.size() > wbase && fetches.size() > fbase) begin
      check("sw_addr", writes[wbase].addr, 32'h40);
      check("sw_data", writes[wbase].data, 32'd12);
      // Counting both the first-fetch and the write-accept cycles.
      check("sw_timing", writes[wbase].cyc - fetches[fbase].cyc + 1, 32'd16);
    end

    // lw with three data wait cycles, result observed through a store.
    prog = '{enc_i(6'h23, 0, 4, 16'h40), enc_i(6'h2B, 0, 4, 16'h44), HALT_W};
    load_prog();
    data_wait = 3;
    apply_reset();
    run_to_halt(200, span);
    data_wait = 0;
    check("lw_req_cycles", data_rd_cycles - rdbase, 32'd4);
    check("lw_addr_stable", data_rd_at40 - rd40base, 32'd4);
    check("lw_sw_count", writes.size() - wbase, 32'd1);
    if (writes.size() > wbase) check("lw_value", writes[wbase].data, 32'd12);
    check("lw_fetches", fetches.size() - fbase, 32'd3);
    if (fetches.size() > fbase + 1)
      check("lw_latency", fetches[fbase+1].cyc - fetches[fbase].cyc, 32'd8);

    // Branch not taken at 0x10, then j 0x100.
    prog = '{enc_i(6'h08, 0, 1, 16'd3), enc_i(6'h08, 0, 2, 16'd9), enc_i(6'h08, 0, 0, 16'd0),
             enc_i(6'h08, 0, 0, 16'd0), enc_i(6'h04, 1, 2, 16'd7), 32'h0800_0100};
    load_prog();
    mem[256] = HALT_W;
    apply_reset();
    run_to_halt(200, span);
    check("br_fetches", fetches.size() - fbase, 32'd7);
    if (fetches.size() > fbase + 6) begin
      check("beq_not_taken", fetches[fbase+5].addr, 32'h14);
      check("jump_target", fetches[fbase+6].addr, 32'h400);
    end

    // beq $0,$0 skips 0x0C; beq $1,$1,-1 at 0x10 loops.
    prog = '{enc_i(6'h08, 0, 1, 16'd1), enc_i(6'h08, 0, 0, 16'd0), enc_i(6'h04, 0, 0, 16'd1),
             HALT_W, enc_i(6'h04, 1, 1, 16'hFFFF)};
    load_prog();
    apply_reset();
    repeat (40) @(negedge clk);
    check("loop_not_halted", {31'b0, halted}, 32'd0);
    check("loop_fetch_min", {31'b0, (fetches.size() - fbase) > 6}, 32'd1);
    if (fetches.size() > fbase + 5) begin
      check("beq_zero_taken", fetches[fbase+3].addr, 32'h10);
      check("loop_fetch_a", fetches[fbase+4].addr, 32'h10);
      check("loop_fetch_b", fetches[fbase+5].addr, 32'h10);
    end

    // Illegal opcode halts; reset recovers.
    prog = '{HALT_W};
    load_prog();
    apply_reset();
    run_to_halt(50, span);
    check("illegal_span", span, 32'd2);
    repeat (10) @(negedge clk);
    check("illegal_no_req", req_while_halted - hbase, 32'd0);
    apply_reset();
    check("rst_clears_halt", {31'b0, halted}, 32'd0);
    @(posedge clk); #1;
    check("refetch_req", {31'b0, bus.mem_req}, 32'd1);
    check("refetch_addr", bus.mem_addr, RESET_PC);

    // Unaligned lw halts without a data access.
    prog = '{enc_i(6'h23, 0, 5, 16'h42), HALT_W};
    load_prog();
    apply_reset();
    run_to_halt(50, span);
    repeat (10) @(negedge clk);
    check("unaligned_no_data", data_rd_cycles - rdbase, 32'd0);
    check("unaligned_fetches", fetches.size() - fbase, 32'd1);
    check("unaligned_no_req", req_while_halted - hbase, 32'd0);

    // Reset during a stalled store abandons it.
    mem[widx(32'h48)] = 32'hDEAD_BEEF;
    prog = '{enc_i(6'h08, 0, 1, 16'h55), enc_i(6'h2B, 0, 1, 16'h48), HALT_W};
    load_prog();
    data_wait = 1000;
    apply_reset();
    hit = 0;
    for (int unsigned k = 0; k < 50 && hit == 0; k++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_we) hit = 1;
    end
    check("store_stalled", hit, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_drops_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_no_write", writes.size() - wbase, 32'd0);
    check("rst_mem_intact", mem[widx(32'h48)], 32'hDEAD_BEEF);
    data_wait = 0;

    // Writes to $0 are discarded.
    mem[widx(32'h4C)] = 32'h1234_5678;
    prog = '{enc_i(6'h08, 0, 1, 16'd5), enc_i(6'h08, 0, 2, 16'd7), enc_r(1, 2, 0, 6'h20),
             enc_i(6'h2B, 0, 0, 16'h4C), HALT_W};
    load_prog();
    apply_reset();
    run_to_halt(200, span);
    check("r0_reads_zero", mem[widx(32'h4C)], 32'd0);

    // Random programs against the reference model.
    for (int t = 0; t < 6; t++) begin
      fetch_wait = $urandom_range(0, 2);
      data_wait  = $urandom_range(0, 2);
      for (int unsigned i = 0; i < 1024; i++) begin mem[i] = '0; mm[i] = '0; end
      for (int unsigned i = 16; i < 128; i++) begin mem[i] = $urandom; mm[i] = mem[i]; end
      prog.delete();
      for (int i = 0; i < 6; i++) begin
        logic [4:0] rs, rt, rd;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: prog.push_back(enc_i(6'h08, rs, rt, 16'($urandom)));
          1: prog.push_back(enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]));
          2: prog.push_back(enc_i(6'h23, 0, rt, 16'(32'h80 + 4 * $urandom_range(0, 31))));
          default: prog.push_back(enc_i(6'h2B, 0, rt, 16'(32'h80 + 4 * $urandom_range(0, 31))));
        endcase
      end
      for (int k = 1; k < 8; k++)
        prog.push_back(enc_i(6'h2B, 0, 5'(k), 16'(32'h180 + 4 * (k - 1))));
      prog.push_back(HALT_W);
      load_prog();
      model_run(exp_span);
      apply_reset();
      run_to_halt(2000, span);
      check("rnd_cycles", span, exp_span);
      for (int unsigned i = 32; i < 128; i++) check("rnd_mem", mem[i], mm[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
